br_resolve: RTL
===============

BR_RESOLVE -- requirements
Module: br_resolve

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the predictor-update FIFO entry count (power of two, at least 2).
REQ-002 clk  input  1  clock.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 br_done_i  input  1  branch ALU result valid this cycle.
REQ-005 br_taken_i  input  1  resolved direction (1 = taken).
REQ-006 br_target_i  input  64  resolved taken target.
REQ-007 br_npc_i  input  64  branch PC+4.
REQ-008 br_rob_idx_i  input  ROB_IDX_W  ROB tag of the branch.
REQ-009 pred_taken_i  input  1  fetch-time predicted direction, aligned with br_done_i.
REQ-010 pred_target_i  input  64  fetch-time predicted target, aligned with br_done_i.
REQ-011 flush_i  input  1  pipeline squash from retirement.
REQ-012 mispred_o  output  1  one-cycle mispredict pulse to ROB.
REQ-013 mispred_rob_idx_o  output  ROB_IDX_W  tag of the mispredicted branch.
REQ-014 recover_pc_o  output  64  correct fetch PC.
REQ-015 bp_upd_valid_o  output  1  predictor update available.
REQ-016 bp_upd_ready_i  input  1  predictor accepts the update.
REQ-017 bp_upd_pc_o  output  64  branch PC of the head entry.
REQ-018 bp_upd_taken_o  output  1  direction of the head entry.
REQ-019 bp_upd_target_o  output  64  target of the head entry.
REQ-020 upd_drop_o  output  1  one-cycle pulse: update dropped because the FIFO was full.
REQ-021 mispred_cnt_o  output  16  saturating mispredict count.

Function
REQ-022 A branch SHALL be mispredicted when pred_taken_i != br_taken_i, or when both are 1 and pred_target_i != br_target_i.
REQ-023 mispred_o, mispred_rob_idx_o and recover_pc_o SHALL be registered, asserting exactly 1 cycle after the accepted br_done_i.
REQ-024 recover_pc_o SHALL be br_target_i if taken, else br_npc_i; when mispred_o is 0 it SHALL hold its last value.
REQ-025 Each accepted br_done_i SHALL push {br_npc_i - 4, br_taken_i, br_target_i} at the FIFO tail, whether or not the branch mispredicted.
REQ-026 A pop SHALL occur when bp_upd_valid_o && bp_upd_ready_i; bp_upd_valid_o SHALL be 1 exactly when the FIFO is non-empty.
REQ-027 Head outputs SHALL be driven directly from the head entry; a push into an empty FIFO SHALL become visible the following cycle.
REQ-028 Head and tail pointers SHALL wrap modulo DEPTH; occupancy SHALL range 0..DEPTH.
REQ-029 On a push with the FIFO full and no simultaneous pop: the entry SHALL be discarded, contents SHALL be unchanged, and upd_drop_o SHALL pulse the next cycle.
REQ-030 On a push with the FIFO full and a simultaneous pop: the push SHALL succeed and occupancy SHALL stay DEPTH.
REQ-031 A simultaneous push and pop on an empty FIFO SHALL NOT bypass; only the push takes effect.
REQ-032 flush_i SHALL empty the FIFO at the next edge, take priority over a same-cycle push and pop, and suppress mispred_o and counting for a same-cycle br_done_i.
REQ-033 mispred_cnt_o SHALL increment on each mispred_o pulse, saturate at 16'hFFFF, and be unaffected by flush_i.
REQ-034 bp_upd_ready_i SHALL NOT affect mispredict outputs.

Reset
REQ-035 On rst, the FIFO SHALL become empty and the following outputs SHALL go to 0: bp_upd_valid_o, mispred_o, mispred_rob_idx_o, recover_pc_o, upd_drop_o, mispred_cnt_o.
REQ-036 rst SHALL take priority over flush_i, push and pop; an in-flight mispredict pulse SHALL be cancelled.

Structure
REQ-037 ROB_IDX_W and the bp_upd entry typedef {pc, taken, target} SHALL live in the shared package.
REQ-038 The FIFO SHALL be one sub-module, br_upd_fifo, with parameter DEPTH and a synchronous clear input.

Verification
REQ-039 pred 0, actual taken, target 64'h1000, npc 64'h2004, tag 5 -> next cycle mispred_o=1, tag 5, recover_pc_o=64'h1000, FIFO head pc=64'h2000.
REQ-040 pred taken with target 64'h1000, actual taken to 64'h1008 -> mispred_o=1, recover_pc_o=64'h1008; with matching targets -> mispred_o=0.
REQ-041 Hold ready=0 and push 5 branches with DEPTH=4 -> 4 stored, upd_drop_o pulses once, pops return the first 4 in order.
REQ-042 Full FIFO with ready=1 and a push the same cycle -> no drop, occupancy stays 4, order preserved across pointer wrap.
REQ-043 flush_i together with br_done_i on a mispredict, 3 entries queued -> no mispred_o, bp_upd_valid_o=0 next cycle, counter unchanged.
REQ-044 Preload the counter to 16'hFFFE and inject 3 mispredicts -> mispred_cnt_o ends at 16'hFFFF; rst mid-stream -> all outputs 0 next cycle.

Source files
------------

// File: rtl/br_resolve_pkg.sv
// Shared types and helpers for branch resolution: ROB tag width, the
// predictor-update entry layout and the mispredict rule.
package br_resolve_pkg;

    localparam int ROB_IDX_W = 6;

    typedef struct packed {
        logic [63:0] pc;
        logic        taken;
        logic [63:0] target;
    } bp_upd_t;

    // A matching direction is only correct for a taken branch if the target matches too.
    function automatic logic is_mispred(
        input logic        pred_taken,
        input logic        taken,
        input logic [63:0] pred_target,
        input logic [63:0] target
    );
        return (pred_taken != taken) || (taken && (pred_target != target));
    endfunction

endpackage

// File: rtl/br_resolve_if.sv
// Bundle of the branch-result, mispredict and predictor-update signals.
interface br_resolve_if;
    import br_resolve_pkg::*;

    logic                 br_done_i;
    logic                 br_taken_i;
    logic [63:0]          br_target_i;
    logic [63:0]          br_npc_i;
    logic [ROB_IDX_W-1:0] br_rob_idx_i;
    logic                 pred_taken_i;
    logic [63:0]          pred_target_i;
    logic                 flush_i;
    logic                 mispred_o;
    logic [ROB_IDX_W-1:0] mispred_rob_idx_o;
    logic [63:0]          recover_pc_o;
    logic                 bp_upd_valid_o;
    logic                 bp_upd_ready_i;
    logic [63:0]          bp_upd_pc_o;
    logic                 bp_upd_taken_o;
    logic [63:0]          bp_upd_target_o;
    logic                 upd_drop_o;
    logic [15:0]          mispred_cnt_o;

    modport slave (
        input  br_done_i, br_taken_i, br_target_i, br_npc_i, br_rob_idx_i,
               pred_taken_i, pred_target_i, flush_i, bp_upd_ready_i,
        output mispred_o, mispred_rob_idx_o, recover_pc_o, bp_upd_valid_o,
               bp_upd_pc_o, bp_upd_taken_o, bp_upd_target_o, upd_drop_o, mispred_cnt_o
    );

    modport master (
        output br_done_i, br_taken_i, br_target_i, br_npc_i, br_rob_idx_i,
               pred_taken_i, pred_target_i, flush_i, bp_upd_ready_i,
        input  mispred_o, mispred_rob_idx_o, recover_pc_o, bp_upd_valid_o,
               bp_upd_pc_o, bp_upd_taken_o, bp_upd_target_o, upd_drop_o, mispred_cnt_o
    );

endinterface

// File: rtl/br_upd_fifo.sv
// Predictor-update FIFO: drops pushes when full unless a pop frees a slot the
// same cycle; clr empties it and overrides push and pop.
module br_upd_fifo
    import br_resolve_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    clr,
    input  logic    push_i,
    input  bp_upd_t push_data_i,
    input  logic    pop_ready_i,
    output logic    valid_o,
    output bp_upd_t head_o,
    output logic    drop_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    bp_upd_t          mem_q [DEPTH];
    bp_upd_t          mem_d [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             drop_q, drop_d;
    logic             pop_s, push_ok_s;

    // Next-state for storage, pointers, occupancy and the drop pulse.
    always_comb begin
        pop_s     = (cnt_q != CNT_W'(0)) && pop_ready_i;
        push_ok_s = push_i && ((cnt_q != FULL_CNT) || pop_s);
        mem_d     = mem_q;
        head_d    = head_q;
        tail_d    = tail_q;
        cnt_d     = cnt_q;
        drop_d    = 1'b0;
        if (clr) begin
            head_d = PTR_W'(0);
            tail_d = PTR_W'(0);
            cnt_d  = CNT_W'(0);
        end else begin
            if (push_ok_s) begin
                mem_d[tail_q] = push_data_i;
                tail_d        = tail_q + PTR_W'(1);
            end else begin
                drop_d = push_i;
            end
            if (pop_s) begin
                head_d = head_q + PTR_W'(1);
            end else begin
                head_d = head_q;
            end
            case ({push_ok_s, pop_s})
                2'b10:   cnt_d = cnt_q + CNT_W'(1);
                2'b01:   cnt_d = cnt_q - CNT_W'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            head_q <= PTR_W'(0);
            tail_q <= PTR_W'(0);
            cnt_q  <= CNT_W'(0);
            drop_q <= 1'b0;
        end else begin
            mem_q  <= mem_d;
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
            drop_q <= drop_d;
        end
    end

    assign valid_o = (cnt_q != CNT_W'(0));
    assign head_o  = mem_q[head_q];
    assign drop_o  = drop_q;

endmodule

// File: rtl/br_resolve.sv
// Branch resolution: detects mispredicts, emits the recovery pulse and PC,
// counts mispredicts and queues every resolved branch for the predictor.
module br_resolve
    import br_resolve_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic  clk,
    input  logic  rst,
    br_resolve_if.slave bus
);

    logic                 mispred_q, mispred_d;
    logic [ROB_IDX_W-1:0] rob_idx_q, rob_idx_d;
    logic [63:0]          recover_pc_q, recover_pc_d;
    logic [15:0]          cnt_q, cnt_d;
    bp_upd_t              upd_s;
    bp_upd_t              head_s;

    // Mispredict detection; a flush squashes a same-cycle result.
    always_comb begin
        mispred_d = bus.br_done_i && !bus.flush_i &&
                    is_mispred(bus.pred_taken_i, bus.br_taken_i,
                               bus.pred_target_i, bus.br_target_i);
        if (mispred_d) begin
            rob_idx_d    = bus.br_rob_idx_i;
            recover_pc_d = bus.br_taken_i ? bus.br_target_i : bus.br_npc_i;
        end else begin
            rob_idx_d    = rob_idx_q;
            recover_pc_d = recover_pc_q;
        end
        if (mispred_q && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
        end else begin
            cnt_d = cnt_q;
        end
        upd_s.pc     = bus.br_npc_i - 64'd4;
        upd_s.taken  = bus.br_taken_i;
        upd_s.target = bus.br_target_i;
    end

    // Mispredict output and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            mispred_q    <= 1'b0;
            rob_idx_q    <= '0;
            recover_pc_q <= 64'd0;
            cnt_q        <= 16'd0;
        end else begin
            mispred_q    <= mispred_d;
            rob_idx_q    <= rob_idx_d;
            recover_pc_q <= recover_pc_d;
            cnt_q        <= cnt_d;
        end
    end

    br_upd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .clr         (bus.flush_i),
        .push_i      (bus.br_done_i),
        .push_data_i (upd_s),
        .pop_ready_i (bus.bp_upd_ready_i),
        .valid_o     (bus.bp_upd_valid_o),
        .head_o      (head_s),
        .drop_o      (bus.upd_drop_o)
    );

    assign bus.mispred_o         = mispred_q;
    assign bus.mispred_rob_idx_o = rob_idx_q;
    assign bus.recover_pc_o      = recover_pc_q;
    assign bus.mispred_cnt_o     = cnt_q;
    assign bus.bp_upd_pc_o       = head_s.pc;
    assign bus.bp_upd_taken_o    = head_s.taken;
    assign bus.bp_upd_target_o   = head_s.target;

endmodule
